// File: rtl/nineteen_bit_serial_subtractor.sv
// Chunk-serial two's-complement subtractor: diff = a - b - borrow_in, CHUNK bits
// per clock, LSB chunk first, with valid/ready handshakes on operands and result.
module nineteen_bit_serial_subtractor #(
  parameter int WIDTH = 19,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. start_ready is high only in IDLE; result_valid only in DONE,
  // with diff/borrow_out/overflow held stable until result_ready is seen.

  localparam int N  = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW = N * CHUNK;
  localparam int IW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [PW-1:0]     a_sh;
  logic [PW-1:0]     b_sh;
  logic [PW-1:0]     res_sh;
  logic              carry;
  logic              a_msb;
  logic              b_msb;
  logic [IW-1:0]     idx;

  logic [CHUNK:0]       sum;
  logic [PW+CHUNK-1:0]  res_cat;
  logic [PW-1:0]        res_next;

  // Operands are zero-padded to whole chunks: padded a bits are 0 and padded
  // ~b bits are 1, so the carry out of the top chunk equals the carry out of
  // bit WIDTH-1 even when the last chunk is partial.
  always_comb begin
    sum      = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, ~b_sh[CHUNK-1:0]} + (CHUNK+1)'(carry);
    res_cat  = {sum[CHUNK-1:0], res_sh};
    res_next = res_cat[PW+CHUNK-1:CHUNK];
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      start_ready  <= 1'b1;
      result_valid <= 1'b0;
      diff         <= '0;
      borrow_out   <= 1'b0;
      overflow     <= 1'b0;
      a_sh         <= '0;
      b_sh         <= '0;
      res_sh       <= '0;
      carry        <= 1'b0;
      a_msb        <= 1'b0;
      b_msb        <= 1'b0;
      idx          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh        <= PW'(a);
            b_sh        <= PW'(b);
            carry       <= ~borrow_in;
            a_msb       <= a[WIDTH-1];
            b_msb       <= b[WIDTH-1];
            res_sh      <= '0;
            idx         <= '0;
            start_ready <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> CHUNK;
          b_sh   <= b_sh >> CHUNK;
          carry  <= sum[CHUNK];
          res_sh <= res_next;
          idx    <= idx + 1'b1;
          if (idx == IW'(N - 1)) begin
            diff         <= res_next[WIDTH-1:0];
            borrow_out   <= ~sum[CHUNK];
            overflow     <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            start_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nineteen_bit_serial_subtractor.sv
// Bench for nineteen_bit_serial_subtractor: CHUNK=1, 4 and 19 instances share
// stimulus and are checked against an arithmetic a - b - borrow_in model.
module tb_nineteen_bit_serial_subtractor;

  localparam int W  = 19;
  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_valid = 1'b0;
  logic          borrow_in = 1'b0;
  logic          result_ready = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;

  logic          sr [ND];
  logic          rv [ND];
  logic          bo [ND];
  logic          ov [ND];
  logic [W-1:0]  df [ND];
  logic [1:0]    st [ND];

  logic [W+1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  nineteen_bit_serial_subtractor #(.WIDTH(W), .CHUNK(1)) u_c1 (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(sr[0]),
    .a(a), .b(b), .borrow_in(borrow_in), .result_valid(rv[0]),
    .result_ready(result_ready), .diff(df[0]), .borrow_out(bo[0]),
    .overflow(ov[0]), .state_dbg(st[0]));

  nineteen_bit_serial_subtractor #(.WIDTH(W), .CHUNK(4)) u_c4 (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(sr[1]),
    .a(a), .b(b), .borrow_in(borrow_in), .result_valid(rv[1]),
    .result_ready(result_ready), .diff(df[1]), .borrow_out(bo[1]),
    .overflow(ov[1]), .state_dbg(st[1]));

  nineteen_bit_serial_subtractor #(.WIDTH(W), .CHUNK(19)) u_c19 (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(sr[2]),
    .a(a), .b(b), .borrow_in(borrow_in), .result_valid(rv[2]),
    .result_ready(result_ready), .diff(df[2]), .borrow_out(bo[2]),
    .overflow(ov[2]), .state_dbg(st[2]));

  function automatic int lat(input int k);
    return (k == 0) ? 19 : ((k == 1) ? 5 : 1);
  endfunction

  // Returns {borrow_out, overflow, diff} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic binv);
    longint ua, ub, ubin, d, sa, sb, sres;
    logic brw, ovf;
    logic [W-1:0] dm;
    ua   = longint'(av);
    ub   = longint'(bv);
    ubin = binv ? 64'sd1 : 64'sd0;
    d    = ua - ub - ubin;
    if (d < 0) d = d + (64'sd1 <<< W);
    dm   = d[W-1:0];
    brw  = (ua < ub + ubin);
    sa   = (ua >= (64'sd1 <<< (W-1))) ? ua - (64'sd1 <<< W) : ua;
    sb   = (ub >= (64'sd1 <<< (W-1))) ? ub - (64'sd1 <<< W) : ub;
    sres = sa - sb - ubin;
    ovf  = (sres < -(64'sd1 <<< (W-1))) || (sres > (64'sd1 <<< (W-1)) - 1);
    return {brw, ovf, dm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if (sr[k] !== 1'b1 || rv[k] !== 1'b0 || df[k] !== '0 || bo[k] !== 1'b0 || ov[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset dut%0d: sr=%b rv=%b diff=%h bo=%b ov=%b, required sr=1 rv=0 diff=0 bo=0 ov=0",
                 k, sr[k], rv[k], df[k], bo[k], ov[k]);
      end
    end
  endtask

  // One full operation on all instances; hold = cycles result_ready stays low
  // after every result is up, poke = fire a start_valid pulse mid-RUN.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                        input int hold, input bit poke);
    int seen [ND];
    int cyc;
    bit pending;
    bit extra;
    logic [W+1:0] e;
    for (int k = 0; k < ND; k++) begin
      seen[k] = -1;
      n_checks++;
      if (sr[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL start_ready_idle dut%0d: got %b, required 1", k, sr[k]);
      end
    end
    exp_q.push_back(model(av, bv, binv));
    a = av;
    b = bv;
    borrow_in = binv;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    borrow_in = 1'($urandom);
    cyc = 0;
    pending = 1'b1;
    while (pending && cyc < 60) begin
      step();
      cyc++;
      if (poke && cyc == 3) start_valid = 1'b1;
      if (cyc == 4) start_valid = 1'b0;
      pending = 1'b0;
      for (int k = 0; k < ND; k++) begin
        if (seen[k] < 0 && rv[k] === 1'b1) seen[k] = cyc;
        if (seen[k] < 0) pending = 1'b1;
      end
    end
    start_valid = 1'b0;
    e = exp_q.pop_front();
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if (seen[k] != lat(k)) begin
        n_fail++;
        $display("FAIL latency dut%0d: result_valid after %0d cycles, required %0d", k, seen[k], lat(k));
      end
      n_checks++;
      if (df[k] !== e[W-1:0] || bo[k] !== e[W+1] || ov[k] !== e[W]) begin
        n_fail++;
        $display("FAIL result dut%0d a=%h b=%h bin=%b: diff=%h bo=%b ov=%b, required diff=%h bo=%b ov=%b",
                 k, av, bv, binv, df[k], bo[k], ov[k], e[W-1:0], e[W+1], e[W]);
      end
    end
    for (int h = 0; h < hold; h++) begin
      step();
      for (int k = 0; k < ND; k++) begin
        n_checks++;
        if (rv[k] !== 1'b1 || sr[k] !== 1'b0 || df[k] !== e[W-1:0] || bo[k] !== e[W+1] || ov[k] !== e[W]) begin
          n_fail++;
          $display("FAIL hold dut%0d cycle %0d: rv=%b sr=%b diff=%h bo=%b ov=%b, required rv=1 sr=0 diff=%h bo=%b ov=%b",
                   k, h, rv[k], sr[k], df[k], bo[k], ov[k], e[W-1:0], e[W+1], e[W]);
        end
      end
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if (rv[k] !== 1'b0 || sr[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL release dut%0d: rv=%b sr=%b, required rv=0 sr=1", k, rv[k], sr[k]);
      end
    end
    if (poke) begin
      extra = 1'b0;
      for (int c = 0; c < 25; c++) begin
        step();
        for (int k = 0; k < ND; k++) if (rv[k] !== 1'b0) extra = 1'b1;
      end
      n_checks++;
      if (extra) begin
        n_fail++;
        $display("FAIL no_queue: got result_valid=1 without an accepted start, required 0");
      end
    end
  endtask

  task automatic test_directed();
    run_op(19'h00005, 19'h00003, 1'b0, 0, 1'b0);
    run_op(19'h00000, 19'h00001, 1'b0, 0, 1'b0);
    run_op(19'h00000, 19'h00000, 1'b1, 0, 1'b0);
    run_op(19'h3FFFF, 19'h7FFFF, 1'b0, 0, 1'b0);
    run_op(19'h40000, 19'h00001, 1'b0, 0, 1'b0);
    run_op(19'h7FFFF, 19'h7FFFF, 1'b1, 0, 1'b0);
  endtask

  task automatic test_hold_and_poke();
    run_op(19'h12345, 19'h0ABCD, 1'b1, 10, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    a = 19'h12345;
    b = 19'h00111;
    borrow_in = 1'b0;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    for (int c = 0; c < 7; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if (sr[k] !== 1'b1 || rv[k] !== 1'b0 || df[k] !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_run dut%0d: sr=%b rv=%b diff=%h, required sr=1 rv=0 diff=0",
                 k, sr[k], rv[k], df[k]);
      end
    end
    run_op(19'h12345, 19'h00111, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv;
    for (int i = 0; i < 2500; i++) begin
      av = W'($urandom);
      bv = W'($urandom);
      case ($urandom_range(0, 7))
        0: av = '0;
        1: bv = {1'b0, {(W-1){1'b1}}};
        2: av = {1'b1, {(W-1){1'b0}}};
        3: bv = av;
        default: ;
      endcase
      run_op(av, bv, 1'($urandom), int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_and_poke();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
